// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard controller.
//   FWD_*    : operand-select encodings driven on ForwardAE/ForwardBE
//   RES_LOAD : ResultSrcE encoding that marks a load in E
//   mc_state_e : multi-cycle execute FSM states
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: combinational forwarding select for one E-stage operand.
//   RegWriteM/RdM : producer in M (highest priority)
//   RegWriteW/RdW : producer in W
//   RsE           : source register of the operand in E
//   fwd           : FWD_M / FWD_W / FWD_RF
// Writes to x0 are never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [REG_AW-1:0] RsE,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
      fwd = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard controller for the 5-stage RV32 pipeline.
//   Inputs : D/E/M/W register addresses and write enables, load marker
//            (ResultSrcE), taken branch (PCSrcE), multi-cycle op flag
//            (MulDivE), perf counter clear (perf_clr), clk, reset_n
//            (synchronous, active low).
//   Outputs: StallF/D/E, FlushD/E/M pipeline-register controls,
//            ForwardAE/BE operand selects, mc_busy, and saturating
//            counters load_stall_cnt, mc_stall_cnt, flush_cnt.
// A multi-cycle op holds E for MC_LAT cycles, stalling F/D/E and
// injecting a bubble into M for the first MC_LAT-1 of them.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MulDivE,
  input  logic              perf_clr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  mc_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned CW       = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam bit          MC_MULTI = (MC_LAT > 1);
  // First RUN cycle already counts as one stall cycle, hence MC_LAT-2.
  localparam logic [CW-1:0] MC_INIT = MC_MULTI ? CW'(MC_LAT - 2) : '0;

  mc_state_e      state_q, state_d;
  logic [CW-1:0]  mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] mc_scnt_q, mc_scnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  logic       mc_stall;
  logic       lw_stall;
  logic [1:0] fwd_a, fwd_b;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .RdM       (RdM),
    .RdW       (RdW),
    .RsE       (Rs1E),
    .fwd       (fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .RdM       (RdM),
    .RdW       (RdW),
    .RsE       (Rs2E),
    .fwd       (fwd_b)
  );

  // Multi-cycle FSM: next state and mc_stall.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    mc_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MulDivE && MC_MULTI) begin
          mc_stall = 1'b1;
          state_d  = RUN;
          mc_cnt_d = MC_INIT;
        end
      end
      RUN: begin
        if (mc_cnt_q != '0) begin
          mc_stall = 1'b1;
          mc_cnt_d = mc_cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    // Outputs are forced quiet while reset is held.
    if (!reset_n) begin
      mc_stall = 1'b0;
    end
  end

  always_comb begin
    lw_stall = reset_n && (ResultSrcE == RES_LOAD) && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));

    StallF    = lw_stall | mc_stall;
    StallD    = lw_stall | mc_stall;
    StallE    = mc_stall;
    FlushM    = mc_stall;
    FlushD    = reset_n & PCSrcE & ~mc_stall;
    FlushE    = (lw_stall | (reset_n & PCSrcE)) & ~mc_stall;
    mc_busy   = mc_stall;
    ForwardAE = reset_n ? fwd_a : FWD_RF;
    ForwardBE = reset_n ? fwd_b : FWD_RF;
  end

  // Saturating performance counters; clear beats increment.
  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    mc_scnt_d = mc_scnt_q;
    fl_cnt_d  = fl_cnt_q;
    if (perf_clr) begin
      ld_cnt_d  = '0;
      mc_scnt_d = '0;
      fl_cnt_d  = '0;
    end else begin
      if (lw_stall && !mc_stall && !(&ld_cnt_q)) ld_cnt_d  = ld_cnt_q + CNT_W'(1);
      if (mc_stall && !(&mc_scnt_q))             mc_scnt_d = mc_scnt_q + CNT_W'(1);
      if (FlushD && !(&fl_cnt_q))                fl_cnt_d  = fl_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mc_cnt_q  <= '0;
      ld_cnt_q  <= '0;
      mc_scnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      mc_cnt_q  <= mc_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      mc_scnt_q <= mc_scnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign load_stall_cnt = ld_cnt_q;
  assign mc_stall_cnt   = mc_scnt_q;
  assign flush_cnt      = fl_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MC_LAT=4, CNT_W=3 so counter
// saturation is reachable). Expected control outputs are written per step;
// expected counters come from a small bench-side counting model.
module tb_hazard_unit_mc;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MulDivE, perf_clr;
  logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [CNT_W-1:0]  load_stall_cnt, mc_stall_cnt, flush_cnt;

  hazard_unit_mc #(.REG_AW(REG_AW), .MC_LAT(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .Rs1D           (Rs1D),
    .Rs2D           (Rs2D),
    .Rs1E           (Rs1E),
    .Rs2E           (Rs2E),
    .RdE            (RdE),
    .RdM            (RdM),
    .RdW            (RdW),
    .RegWriteM      (RegWriteM),
    .RegWriteW      (RegWriteW),
    .ResultSrcE     (ResultSrcE),
    .PCSrcE         (PCSrcE),
    .MulDivE        (MulDivE),
    .perf_clr       (perf_clr),
    .StallF         (StallF),
    .StallD         (StallD),
    .StallE         (StallE),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .FlushM         (FlushM),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .mc_busy        (mc_busy),
    .load_stall_cnt (load_stall_cnt),
    .mc_stall_cnt   (mc_stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy}
  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [CNT_W-1:0] ld;
    logic [CNT_W-1:0] mc;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic [CNT_W-1:0] m_ld = '0, m_mc = '0, m_fl = '0;

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] MCST  = 7'b1110011;
  localparam logic [6:0] LDST  = 7'b1100100;
  localparam logic [6:0] BRFL  = 7'b0001100;
  localparam logic [6:0] LDBR  = 7'b1101100;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; MulDivE = 1'b0; perf_clr = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic chk(input string tag, input logic [6:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
    e.ld = m_ld; e.mc = m_mc; e.fl = m_fl;
    q.push_back(e);
    #2;
    e = q.pop_front();
    vectors++;
    assert ({StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy} === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl got %b want %b", e.tag,
             {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy}, e.ctl);
    end
    vectors++;
    assert (ForwardAE === e.fa) else begin
      miscompares++; $error("FAIL %s ForwardAE got %b want %b", e.tag, ForwardAE, e.fa);
    end
    vectors++;
    assert (ForwardBE === e.fb) else begin
      miscompares++; $error("FAIL %s ForwardBE got %b want %b", e.tag, ForwardBE, e.fb);
    end
    vectors++;
    assert (load_stall_cnt === e.ld) else begin
      miscompares++; $error("FAIL %s load_stall_cnt got %0d want %0d", e.tag, load_stall_cnt, e.ld);
    end
    vectors++;
    assert (mc_stall_cnt === e.mc) else begin
      miscompares++; $error("FAIL %s mc_stall_cnt got %0d want %0d", e.tag, mc_stall_cnt, e.mc);
    end
    vectors++;
    assert (flush_cnt === e.fl) else begin
      miscompares++; $error("FAIL %s flush_cnt got %0d want %0d", e.tag, flush_cnt, e.fl);
    end
    @(posedge clk);
    if (!reset_n || perf_clr) begin
      m_ld = '0; m_mc = '0; m_fl = '0;
    end else begin
      if (ctl[5] && !ctl[4]) m_ld = sat_inc(m_ld);
      if (ctl[4])            m_mc = sat_inc(m_mc);
      if (ctl[3])            m_fl = sat_inc(m_fl);
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset holds every output quiet even with hazard-causing inputs.
    MulDivE = 1'b1; PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    chk("reset", NONE, 2'b00, 2'b00);

    reset_n = 1'b1; clear_inputs();
    Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    chk("fwd_m_prio", NONE, 2'b10, 2'b00);
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    chk("fwd_x0", NONE, 2'b00, 2'b00);
    RdM = 5'd3; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd3;
    chk("fwd_w_and_m", NONE, 2'b01, 2'b10);
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    chk("fwd_no_we", NONE, 2'b00, 2'b00);

    clear_inputs(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    chk("load_use", LDST, 2'b00, 2'b00);
    clear_inputs();
    chk("load_use_after", NONE, 2'b00, 2'b00);
    ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
    chk("load_x0", NONE, 2'b00, 2'b00);

    clear_inputs(); PCSrcE = 1'b1;
    chk("branch", BRFL, 2'b00, 2'b00);
    clear_inputs();
    chk("branch_after", NONE, 2'b00, 2'b00);

    // Two back-to-back multi-cycle ops; hazards during the stall are ignored.
    MulDivE = 1'b1;
    for (int unsigned op = 0; op < 2; op++) begin
      chk("mc_c1", MCST, 2'b00, 2'b00);
      if (op == 1) begin
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
      end
      chk("mc_c2", MCST, 2'b00, 2'b00);
      PCSrcE = 1'b0; ResultSrcE = 2'b00;
      chk("mc_c3", MCST, 2'b00, 2'b00);
      chk("mc_release", NONE, 2'b00, 2'b00);
    end
    clear_inputs();
    chk("mc_idle", NONE, 2'b00, 2'b00);

    perf_clr = 1'b1;
    chk("perf_clr", NONE, 2'b00, 2'b00);
    perf_clr = 1'b0;
    chk("perf_clr_after", NONE, 2'b00, 2'b00);

    // Reset during the second cycle of an op aborts it.
    MulDivE = 1'b1;
    chk("mcr_c1", MCST, 2'b00, 2'b00);
    reset_n = 1'b0; Rs1E = 5'd4; RdW = 5'd4; RegWriteW = 1'b1;
    chk("mcr_reset", NONE, 2'b00, 2'b00);
    reset_n = 1'b1; clear_inputs();
    chk("mcr_idle", NONE, 2'b00, 2'b00);
    MulDivE = 1'b1;
    chk("mcr_restart", MCST, 2'b00, 2'b00);
    reset_n = 1'b0; clear_inputs();
    chk("reset2", NONE, 2'b00, 2'b00);
    reset_n = 1'b1;

    ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
    chk("load_and_branch", LDBR, 2'b00, 2'b00);

    clear_inputs(); ResultSrcE = 2'b01; RdE = 5'd12; Rs1D = 5'd12;
    for (int unsigned i = 0; i < 10; i++) begin
      chk("load_sat", LDST, 2'b00, 2'b00);
    end
    clear_inputs();
    chk("load_sat_hold", NONE, 2'b00, 2'b00);
    perf_clr = 1'b1;
    chk("sat_clr", NONE, 2'b00, 2'b00);
    perf_clr = 1'b0;
    chk("sat_clr_after", NONE, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
